// File: rtl/imr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imr_ctrl
// Purpose  : Clocked interrupt mask register for the PIC. It holds the mask
//            in registered state behind a two-state init sequencer. It
//            supports full OCW1 writes, single-bit set/clear, special mask
//            mode (SMM) and a registered readback path.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            init_start/init_done  - ICW1 seen / last ICW accepted
//            ocw1_wr, ocw1_data    - full mask write
//            bit_op_*              - single-bit mask set/clear
//            smm_cmd_valid/smm_cmd - OCW3 enter/leave special mask mode
//            rd_en -> rd_valid/rd_data - registered mask readback
//            irr_in/isr_in         - raw request / in-service bits
//            imr, masked_irr, isr_block, smm_active, ready - status outputs
// Revision : 1.0 - initial release
// ============================================================================
module imr_ctrl #(
   parameter int                 NUM_IRQ      = 8,
   parameter int                 IDX_W        = $clog2(NUM_IRQ),
   parameter logic [NUM_IRQ-1:0] MASK_RST_VAL = '0,
   parameter bit                 ENABLE_SMM   = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               init_start,
   input  logic               init_done,
   input  logic               ocw1_wr,
   input  logic [NUM_IRQ-1:0] ocw1_data,
   input  logic               bit_op_valid,
   input  logic               bit_op_set,
   input  logic [IDX_W-1:0]   bit_op_idx,
   input  logic               smm_cmd_valid,
   input  logic               smm_cmd,
   input  logic               rd_en,
   input  logic [NUM_IRQ-1:0] irr_in,
   input  logic [NUM_IRQ-1:0] isr_in,
   output logic [NUM_IRQ-1:0] imr,
   output logic [NUM_IRQ-1:0] masked_irr,
   output logic [NUM_IRQ-1:0] isr_block,
   output logic               smm_active,
   output logic               ready,
   output logic [NUM_IRQ-1:0] rd_data,
   output logic               rd_valid
);

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_IRQ-1:0] imr_q, imr_d;
   logic [NUM_IRQ-1:0] rd_data_q, rd_data_d;
   logic               smm_q, smm_d;
   logic               ready_q, ready_d;
   logic               rd_valid_q, rd_valid_d;

   always_comb begin
      state_d    = state_q;
      imr_d      = imr_q;
      smm_d      = smm_q;
      // Readback samples the mask before any write landing this cycle.
      rd_valid_d = rd_en;
      rd_data_d  = rd_en ? imr_q : rd_data_q;

      if (init_start) begin
         // A new ICW1 restarts initialisation regardless of state and
         // beats a coincident init_done.
         state_d = ST_INIT;
         imr_d   = MASK_RST_VAL;
         smm_d   = 1'b0;
      end else if (state_q == ST_INIT) begin
         if (init_done) begin
            state_d = ST_READY;
         end
      end else begin
         if (ocw1_wr) begin
            imr_d = ocw1_data;
         end else if (bit_op_valid) begin
            // Matching against each channel number makes any index at or
            // beyond NUM_IRQ fall through as a no-op.
            for (int i = 0; i < NUM_IRQ; i++) begin
               if (bit_op_idx == IDX_W'(i)) begin
                  imr_d[i] = bit_op_set;
               end
            end
         end
         // SMM is independent of mask writes and may update alongside them.
         if (ENABLE_SMM && smm_cmd_valid) begin
            smm_d = smm_cmd;
         end
      end

      ready_d = (state_d == ST_READY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         imr_q      <= MASK_RST_VAL;
         smm_q      <= 1'b0;
         ready_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         imr_q      <= imr_d;
         smm_q      <= smm_d;
         ready_q    <= ready_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign imr        = imr_q;
   assign smm_active = smm_q;
   assign ready      = ready_q;
   assign rd_valid   = rd_valid_q;
   assign rd_data    = rd_data_q;
   assign masked_irr = irr_in & ~imr_q;
   // Under SMM a masked in-service level no longer blocks lower priorities.
   assign isr_block  = smm_q ? (isr_in & ~imr_q) : isr_in;

endmodule
`default_nettype wire

// File: tb/tb_imr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imr_ctrl
// Purpose  : Self-checking bench for imr_ctrl. Three builds share stimulus:
//            a = 8 channels, b = 16 channels with all-ones reset mask,
//            c = 5 channels (so 3-bit indices 5..7 are out of range).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imr_ctrl;

   typedef struct {
      logic [15:0] imr;
      logic [15:0] mirr;
      logic [15:0] isrb;
      logic [15:0] rdd;
      logic        smm;
      logic        rdy;
      logic        rdv;
   } exp_t;

   localparam int          NW  [3] = '{8, 16, 5};
   localparam int          IW  [3] = '{3, 4, 3};
   localparam logic [15:0] RST [3] = '{16'h0000, 16'hFFFF, 16'h0000};
   string DN [3] = '{"a", "b", "c"};

   logic        clk;
   logic        rst_n;
   logic        init_start, init_done, ocw1_wr, bit_op_valid, bit_op_set;
   logic        smm_cmd_valid, smm_cmd, rd_en;
   logic [15:0] ocw1_data, irr, isr;
   logic [3:0]  idx;

   logic [7:0]  a_imr, a_mirr, a_isrb, a_rdd;
   logic        a_smm, a_rdy, a_rdv;
   logic [15:0] b_imr, b_mirr, b_isrb, b_rdd;
   logic        b_smm, b_rdy, b_rdv;
   logic [4:0]  c_imr, c_mirr, c_isrb, c_rdd;
   logic        c_smm, c_rdy, c_rdv;

   int n_assert = 0;
   int n_fail   = 0;

   exp_t        sb [$];
   logic [15:0] m_imr [3];
   logic [15:0] m_rdd [3];
   logic        m_smm [3];
   logic        m_rdy;

   imr_ctrl #(.NUM_IRQ(8)) u_a (
      .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_done(init_done),
      .ocw1_wr(ocw1_wr), .ocw1_data(ocw1_data[7:0]), .bit_op_valid(bit_op_valid),
      .bit_op_set(bit_op_set), .bit_op_idx(idx[2:0]), .smm_cmd_valid(smm_cmd_valid),
      .smm_cmd(smm_cmd), .rd_en(rd_en), .irr_in(irr[7:0]), .isr_in(isr[7:0]),
      .imr(a_imr), .masked_irr(a_mirr), .isr_block(a_isrb), .smm_active(a_smm),
      .ready(a_rdy), .rd_data(a_rdd), .rd_valid(a_rdv));

   imr_ctrl #(.NUM_IRQ(16), .MASK_RST_VAL(16'hFFFF)) u_b (
      .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_done(init_done),
      .ocw1_wr(ocw1_wr), .ocw1_data(ocw1_data), .bit_op_valid(bit_op_valid),
      .bit_op_set(bit_op_set), .bit_op_idx(idx), .smm_cmd_valid(smm_cmd_valid),
      .smm_cmd(smm_cmd), .rd_en(rd_en), .irr_in(irr), .isr_in(isr),
      .imr(b_imr), .masked_irr(b_mirr), .isr_block(b_isrb), .smm_active(b_smm),
      .ready(b_rdy), .rd_data(b_rdd), .rd_valid(b_rdv));

   imr_ctrl #(.NUM_IRQ(5)) u_c (
      .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_done(init_done),
      .ocw1_wr(ocw1_wr), .ocw1_data(ocw1_data[4:0]), .bit_op_valid(bit_op_valid),
      .bit_op_set(bit_op_set), .bit_op_idx(idx[2:0]), .smm_cmd_valid(smm_cmd_valid),
      .smm_cmd(smm_cmd), .rd_en(rd_en), .irr_in(irr[4:0]), .isr_in(isr[4:0]),
      .imr(c_imr), .masked_irr(c_mirr), .isr_block(c_isrb), .smm_active(c_smm),
      .ready(c_rdy), .rd_data(c_rdd), .rd_valid(c_rdv));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t observe(input int d);
      exp_t o;
      o = '{default: '0};
      case (d)
         0: begin
            o.imr = 16'(a_imr); o.mirr = 16'(a_mirr); o.isrb = 16'(a_isrb);
            o.rdd = 16'(a_rdd); o.smm = a_smm; o.rdy = a_rdy; o.rdv = a_rdv;
         end
         1: begin
            o.imr = b_imr; o.mirr = b_mirr; o.isrb = b_isrb;
            o.rdd = b_rdd; o.smm = b_smm; o.rdy = b_rdy; o.rdv = b_rdv;
         end
         default: begin
            o.imr = 16'(c_imr); o.mirr = 16'(c_mirr); o.isrb = 16'(c_isrb);
            o.rdd = 16'(c_rdd); o.smm = c_smm; o.rdy = c_rdy; o.rdv = c_rdv;
         end
      endcase
      return o;
   endfunction

   task automatic compare(input string t, input int d, input exp_t e);
      exp_t o;
      o = observe(d);
      check({t, ".", DN[d], ".imr"},        32'(o.imr),  32'(e.imr));
      check({t, ".", DN[d], ".masked_irr"}, 32'(o.mirr), 32'(e.mirr));
      check({t, ".", DN[d], ".isr_block"},  32'(o.isrb), 32'(e.isrb));
      check({t, ".", DN[d], ".smm_active"}, 32'(o.smm),  32'(e.smm));
      check({t, ".", DN[d], ".ready"},      32'(o.rdy),  32'(e.rdy));
      check({t, ".", DN[d], ".rd_valid"},   32'(o.rdv),  32'(e.rdv));
      check({t, ".", DN[d], ".rd_data"},    32'(o.rdd),  32'(e.rdd));
   endtask

   task automatic clear_strobes();
      init_start    = 1'b0;
      init_done     = 1'b0;
      ocw1_wr       = 1'b0;
      bit_op_valid  = 1'b0;
      smm_cmd_valid = 1'b0;
      rd_en         = 1'b0;
   endtask

   // Reference model of one clock edge: expectations are pushed before the
   // edge and popped against the DUT outputs just after it.
   task automatic step(input string t);
      exp_t e;
      logic nrdy;
      nrdy = m_rdy;
      if (init_start)              nrdy = 1'b0;
      else if (!m_rdy && init_done) nrdy = 1'b1;
      for (int d = 0; d < 3; d++) begin
         logic [15:0] wm, ni;
         logic        ns;
         int          di;
         wm = 16'((32'd1 << NW[d]) - 32'd1);
         ni = m_imr[d];
         ns = m_smm[d];
         if (rd_en) m_rdd[d] = m_imr[d];
         if (init_start) begin
            ni = RST[d];
            ns = 1'b0;
         end else if (m_rdy) begin
            di = int'(idx) % (1 << IW[d]);
            if (ocw1_wr)                          ni = ocw1_data & wm;
            else if (bit_op_valid && di < NW[d])  ni[di] = bit_op_set;
            if (smm_cmd_valid)                    ns = smm_cmd;
         end
         m_imr[d] = ni;
         m_smm[d] = ns;
         e.imr  = ni;
         e.smm  = ns;
         e.rdy  = nrdy;
         e.rdv  = rd_en;
         e.rdd  = m_rdd[d];
         e.mirr = irr & ~ni & wm;
         e.isrb = (ns ? (isr & ~ni) : isr) & wm;
         sb.push_back(e);
      end
      m_rdy = nrdy;
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         e = sb.pop_front();
         compare(t, d, e);
      end
      clear_strobes();
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_imr[d] = RST[d];
         m_smm[d] = 1'b0;
         m_rdd[d] = '0;
      end
      m_rdy = 1'b0;
   endtask

   task automatic check_reset_now(input string t);
      exp_t e;
      model_reset();
      for (int d = 0; d < 3; d++) begin
         e.imr  = RST[d];
         e.smm  = 1'b0;
         e.rdy  = 1'b0;
         e.rdv  = 1'b0;
         e.rdd  = '0;
         e.mirr = irr & ~RST[d] & 16'((32'd1 << NW[d]) - 32'd1);
         e.isrb = isr & 16'((32'd1 << NW[d]) - 32'd1);
         compare(t, d, e);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      clear_strobes();
      bit_op_set = 1'b0;
      smm_cmd    = 1'b0;
      ocw1_data  = '0;
      irr        = '0;
      isr        = '0;
      idx        = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_now("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Writes, bit ops and SMM commands are ignored during INIT.
      ocw1_wr = 1'b1; ocw1_data = 16'h00AA;                      step("init_ocw1");
      bit_op_valid = 1'b1; bit_op_set = 1'b1; idx = 4'd2;        step("init_bitop");
      smm_cmd_valid = 1'b1; smm_cmd = 1'b1;                      step("init_smm");
      init_done = 1'b1;                                          step("init_done");

      // Full write and IRR masking.
      ocw1_wr = 1'b1; ocw1_data = 16'h00F0; irr = 16'hFFFF;      step("ocw1_f0");

      // Readback returns the pre-write mask, then the new one, then holds.
      rd_en = 1'b1; ocw1_wr = 1'b1; ocw1_data = 16'h003C;        step("rd_old");
      rd_en = 1'b1;                                              step("rd_new");
      step("rd_hold");

      // Single-bit set/clear and out-of-range indices.
      ocw1_wr = 1'b1; ocw1_data = 16'h0000;                      step("clr_all");
      bit_op_valid = 1'b1; bit_op_set = 1'b1; idx = 4'd3;        step("set3");
      bit_op_valid = 1'b1; bit_op_set = 1'b0; idx = 4'd3;        step("clr3");
      bit_op_valid = 1'b1; bit_op_set = 1'b1; idx = 4'd6;        step("set6");
      bit_op_valid = 1'b1; bit_op_set = 1'b1; idx = 4'd15;       step("set15");
      bit_op_valid = 1'b1; bit_op_set = 1'b0; idx = 4'd7;        step("clr7");

      // Full write beats a same-cycle bit op.
      ocw1_wr = 1'b1; ocw1_data = 16'h000F;
      bit_op_valid = 1'b1; bit_op_set = 1'b1; idx = 4'd7;        step("ocw1_vs_bitop");

      // Special mask mode.
      ocw1_wr = 1'b1; ocw1_data = 16'h0004; isr = 16'h0006;      step("imr_04");
      smm_cmd_valid = 1'b1; smm_cmd = 1'b1;                      step("smm_on");
      smm_cmd_valid = 1'b1; smm_cmd = 1'b0;                      step("smm_off");
      smm_cmd_valid = 1'b1; smm_cmd = 1'b1;
      ocw1_wr = 1'b1; ocw1_data = 16'h0002;                      step("smm_with_wr");

      // init_start beats ocw1_wr and init_done; clears SMM.
      init_start = 1'b1; init_done = 1'b1;
      ocw1_wr = 1'b1; ocw1_data = 16'h0055;                      step("restart");
      init_done = 1'b1;                                          step("reinit_done");

      // Asynchronous reset mid-operation with a full mask, SMM on and a read
      // in flight.
      ocw1_wr = 1'b1; ocw1_data = 16'hFFFF;
      smm_cmd_valid = 1'b1; smm_cmd = 1'b1;                      step("all_masked");
      rd_en = 1'b1;                                              step("rd_pending");
      #2 rst_n = 1'b0;
      #1;
      check_reset_now("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      step("post_reset");

      // Randomised mix of all commands.
      for (int n = 0; n < 300; n++) begin
         init_start    = ($urandom_range(0, 15) == 0);
         init_done     = ($urandom_range(0, 3) == 0);
         ocw1_wr       = ($urandom_range(0, 3) == 0);
         ocw1_data     = 16'($urandom);
         bit_op_valid  = $urandom_range(0, 1) == 1;
         bit_op_set    = $urandom_range(0, 1) == 1;
         idx           = 4'($urandom_range(0, 15));
         smm_cmd_valid = ($urandom_range(0, 3) == 0);
         smm_cmd       = $urandom_range(0, 1) == 1;
         rd_en         = $urandom_range(0, 1) == 1;
         irr           = 16'($urandom);
         isr           = 16'($urandom);
         step("rand");
      end

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
